// File: rtl/spi_master_arb.sv
// spi_master_arb: two-requester round-robin SPI mode-0 master.
//
// Ports:
//   sys_clk, sys_rst_n   clock and synchronous active-low reset
//   req[1:0]             per-requester transfer request (level)
//   tx_data0/1           per-requester transmit word, captured at grant
//   gnt[1:0]             one-hot grant for the requester being served
//   done[1:0]            one-cycle completion pulse
//   rx_data              received word, updated in the done cycle
//   CS, SCLK, MOSI, MISO SPI bus pins (CS active low, CPOL=0, CPHA=0)
module spi_master_arb #(
    parameter int DATA_W   = 8,
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [1:0]        req,
    input  logic [DATA_W-1:0] tx_data0,
    input  logic [DATA_W-1:0] tx_data1,
    output logic [1:0]        gnt,
    output logic [1:0]        done,
    output logic [DATA_W-1:0] rx_data,
    output logic              CS,
    output logic              SCLK,
    output logic              MOSI,
    input  logic              MISO
);

    localparam int CNT_M1  = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int CNT_MAX = (CNT_M1 > CS_HOLD) ? CNT_M1 : CS_HOLD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = $clog2(DATA_W);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [BIT_W-1:0]  r_bit;
    logic [DATA_W-1:0] r_tx;
    logic [DATA_W-1:0] r_rx;
    logic [DATA_W-1:0] r_rx_data;
    logic [1:0]        r_gnt;
    logic [1:0]        r_done;
    logic              r_cs;
    logic              r_sclk;
    logic              r_win;
    logic              r_last;

    // The requester just completed is masked in its done cycle.
    logic [1:0]        w_req;
    logic              w_any;
    logic              w_pick1;
    logic [DATA_W-1:0] w_tx;

    assign w_req   = req & ~r_done;
    assign w_any   = |w_req;
    // r_last is the requester served most recently; the other one wins ties.
    assign w_pick1 = w_req[1] & (~w_req[0] | ~r_last);
    assign w_tx    = w_pick1 ? tx_data1 : tx_data0;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_rx_data <= '0;
            r_gnt     <= 2'b00;
            r_done    <= 2'b00;
            r_cs      <= 1'b1;
            r_sclk    <= 1'b0;
            r_win     <= 1'b0;
            r_last    <= 1'b1;
        end else begin
            r_done <= 2'b00;
            unique case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state <= SETUP;
                        r_win   <= w_pick1;
                        r_gnt   <= w_pick1 ? 2'b10 : 2'b01;
                        r_cs    <= 1'b0;
                        r_tx    <= w_tx;
                        r_cnt   <= CNT_W'(CS_SETUP - 1);
                    end
                end
                SETUP: begin
                    if (r_cnt == '0) begin
                        r_state <= SHIFT;
                        r_cnt   <= CNT_W'(CLK_DIV - 1);
                        r_bit   <= '0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                SHIFT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_cnt <= CNT_W'(CLK_DIV - 1);
                        if (!r_sclk) begin
                            r_sclk <= 1'b1;
                            r_rx   <= {r_rx[DATA_W-2:0], MISO};
                        end else begin
                            r_sclk <= 1'b0;
                            // The shift on the final fall empties r_tx,
                            // which parks MOSI low for HOLD and IDLE.
                            r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
                            if (r_bit == BIT_W'(DATA_W - 1)) begin
                                r_state <= HOLD;
                                r_cnt   <= CNT_W'(CS_HOLD - 1);
                            end else begin
                                r_bit <= r_bit + 1'b1;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (r_cnt == '0) begin
                        r_state   <= IDLE;
                        r_cs      <= 1'b1;
                        r_gnt     <= 2'b00;
                        r_done    <= r_win ? 2'b10 : 2'b01;
                        r_rx_data <= r_rx;
                        r_last    <= r_win;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign done    = r_done;
    assign rx_data = r_rx_data;
    assign CS      = r_cs;
    assign SCLK    = r_sclk;
    assign MOSI    = r_tx[DATA_W-1];

endmodule

// File: tb/tb_spi_master_arb.sv
// tb_spi_master_arb: directed, table-driven bench for spi_master_arb.
// Default-parameter DUT plus a fast-timing DUT (CLK_DIV=CS_SETUP=CS_HOLD=1).
module tb_spi_master_arb;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [1:0] req;
    logic [7:0] tx0, tx1;
    logic       loop, miso_drv, miso;
    logic [1:0] gnt, done;
    logic [7:0] rx;
    logic       cs, sclk, mosi;

    logic [1:0] reqb;
    logic [7:0] txb0, txb1;
    logic [1:0] gntb, doneb;
    logic [7:0] rxb;
    logic       csb, sclkb, mosib, misob;

    assign miso  = loop ? mosi : miso_drv;
    assign misob = mosib;

    spi_master_arb dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .req(req),
        .tx_data0(tx0), .tx_data1(tx1), .gnt(gnt), .done(done),
        .rx_data(rx), .CS(cs), .SCLK(sclk), .MOSI(mosi), .MISO(miso)
    );

    spi_master_arb #(.DATA_W(8), .CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1)) dutb (
        .sys_clk(clk), .sys_rst_n(rst_n), .req(reqb),
        .tx_data0(txb0), .tx_data1(txb1), .gnt(gntb), .done(doneb),
        .rx_data(rxb), .CS(csb), .SCLK(sclkb), .MOSI(mosib), .MISO(misob)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] rq;
        logic [7:0] t0;
        logic [7:0] t1;
        logic       lp;
        logic [7:0] mw;
        int         chg;
        logic [7:0] chgv;
        logic [1:0] egnt;
        logic [7:0] emosi;
        logic [7:0] erx;
    } vec_t;

    vec_t vt[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    // Issue one request, act as a mode-0 slave on MISO and watch the frame.
    task automatic run_frame(input logic [1:0] rq, input logic [7:0] mw,
                             input int chg, input logic [7:0] chgv,
                             output int dcyc, output logic [1:0] dval,
                             output logic [1:0] g1, output logic [7:0] mw_o,
                             output logic [7:0] rxw, output logic csd,
                             output int r1);
        int   mi;
        logic ps;
        mi   = 7;
        ps   = 1'b0;
        dcyc = -1;
        r1   = -1;
        dval = 2'b00;
        g1   = 2'b00;
        mw_o = 8'h00;
        rxw  = 8'h00;
        csd  = 1'b0;
        miso_drv = mw[7];
        req  = rq;
        for (int c = 1; c <= 200 && dcyc < 0; c++) begin
            tick();
            if (c == 1) g1 = gnt;
            if (c == chg) tx1 = chgv;
            if (sclk && !ps) begin
                mw_o = {mw_o[6:0], mosi};
                if (r1 < 0) r1 = c;
            end
            if (!sclk && ps) begin
                if (mi > 0) mi--;
                miso_drv = mw[mi];
            end
            ps = sclk;
            if (done != 2'b00) begin
                dcyc = c;
                dval = done;
                rxw  = rx;
                csd  = cs;
                req  = 2'b00;
            end
        end
        req = 2'b00;
        tick();
    endtask

    int         dcyc, r1, r2, d0, d1, ng, nd, same;
    logic [1:0] dval, g1, pg, drop;
    logic [7:0] mw_o, rxw;
    logic       csd, ps;
    int         g_cyc[4];
    logic [1:0] g_val[4];

    initial begin
        vt[0] = '{2'b01, 8'hA5, 8'h00, 1'b1, 8'h00, 0, 8'h00, 2'b01, 8'hA5, 8'hA5};
        vt[1] = '{2'b10, 8'h00, 8'h0F, 1'b0, 8'h3C, 5, 8'hFF, 2'b10, 8'h0F, 8'h3C};
        vt[2] = '{2'b11, 8'h5A, 8'hC3, 1'b1, 8'h00, 0, 8'h00, 2'b01, 8'h5A, 8'h5A};
        vt[3] = '{2'b11, 8'h5A, 8'hC3, 1'b1, 8'h00, 0, 8'h00, 2'b10, 8'hC3, 8'hC3};
        vt[4] = '{2'b01, 8'h00, 8'h77, 1'b0, 8'hFF, 0, 8'h00, 2'b01, 8'h00, 8'hFF};
        vt[5] = '{2'b10, 8'h66, 8'h80, 1'b0, 8'h01, 0, 8'h00, 2'b10, 8'h80, 8'h01};

        rst_n = 1'b0;
        req = 2'b00; tx0 = 8'h00; tx1 = 8'h00;
        loop = 1'b1; miso_drv = 1'b0;
        reqb = 2'b00; txb0 = 8'h00; txb1 = 8'h00;
        repeat (3) tick();
        chk("rst_cs", 32'(cs), 1);
        chk("rst_sclk", 32'(sclk), 0);
        chk("rst_mosi", 32'(mosi), 0);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_rx", 32'(rx), 0);
        rst_n = 1'b1;
        tick();

        // Abort a frame with reset at cycle 20.
        tx0 = 8'h33;
        req = 2'b01;
        repeat (20) tick();
        chk("mid_cs_low", 32'(cs), 0);
        rst_n = 1'b0;
        tick();
        chk("abort_cs", 32'(cs), 1);
        chk("abort_sclk", 32'(sclk), 0);
        chk("abort_gnt", 32'(gnt), 0);
        req = 2'b00;
        tick();
        rst_n = 1'b1;
        nd = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (done != 2'b00 || cs != 1'b1) nd++;
        end
        chk("abort_no_done", 32'(nd), 0);
        chk("abort_rx", 32'(rx), 0);

        for (int i = 0; i < 6; i++) begin
            tx0  = vt[i].t0;
            tx1  = vt[i].t1;
            loop = vt[i].lp;
            run_frame(vt[i].rq, vt[i].mw, vt[i].chg, vt[i].chgv,
                      dcyc, dval, g1, mw_o, rxw, csd, r1);
            chk($sformatf("v%0d_gnt", i), 32'(g1), 32'(vt[i].egnt));
            chk($sformatf("v%0d_dcyc", i), dcyc, 69);
            chk($sformatf("v%0d_done", i), 32'(dval), 32'(vt[i].egnt));
            chk($sformatf("v%0d_mosi", i), 32'(mw_o), 32'(vt[i].emosi));
            chk($sformatf("v%0d_rx", i), 32'(rxw), 32'(vt[i].erx));
            chk($sformatf("v%0d_cs", i), 32'(csd), 1);
            chk($sformatf("v%0d_rise1", i), r1, 7);
        end

        // Contention: both request, each drops req the cycle after its done.
        loop = 1'b1;
        tx0 = 8'h11; tx1 = 8'h22;
        ng = 0; d0 = -1; d1 = -1; pg = 2'b00; drop = 2'b00;
        req = 2'b11;
        for (int c = 1; c <= 300 && d1 < 0; c++) begin
            tick();
            req  = req & ~drop;
            drop = done;
            if (gnt != 2'b00 && pg == 2'b00 && ng < 4) begin
                g_cyc[ng] = c;
                g_val[ng] = gnt;
                ng++;
            end
            pg = gnt;
            if (done[0] && d0 < 0) d0 = c;
            if (done[1] && d1 < 0) d1 = c;
        end
        req = 2'b00;
        chk("cont_ngnt", ng, 2);
        chk("cont_g0_cyc", g_cyc[0], 1);
        chk("cont_g0", 32'(g_val[0]), 32'h1);
        chk("cont_g1_cyc", g_cyc[1], 70);
        chk("cont_g1", 32'(g_val[1]), 32'h2);
        chk("cont_d0", d0, 69);
        chk("cont_d1", d1, 138);
        repeat (2) tick();

        // Fairness: both hold req for four frames.
        ng = 0; nd = 0; same = 0; pg = 2'b00; d1 = -1;
        req = 2'b11;
        for (int c = 1; c <= 400 && nd < 4; c++) begin
            tick();
            if (gnt != 2'b00 && pg == 2'b00 && ng < 4) begin
                g_cyc[ng] = c;
                g_val[ng] = gnt;
                if (ng > 0 && g_val[ng] == g_val[ng-1]) same++;
                ng++;
                if (ng == 4) req = 2'b00;
            end
            pg = gnt;
            if (done != 2'b00) begin
                nd++;
                d1 = c;
            end
        end
        req = 2'b00;
        chk("fair_g0", 32'(g_val[0]), 32'h1);
        chk("fair_g1", 32'(g_val[1]), 32'h2);
        chk("fair_g2", 32'(g_val[2]), 32'h1);
        chk("fair_g3", 32'(g_val[3]), 32'h2);
        chk("fair_g3_cyc", g_cyc[3], 208);
        chk("fair_repeat", same, 0);
        chk("fair_last_done", d1, 276);
        repeat (2) tick();

        // Fast timing DUT.
        txb0 = 8'h96;
        reqb = 2'b01;
        r1 = -1; r2 = -1; dcyc = -1; ps = 1'b0; dval = 2'b00; rxw = 8'h00;
        for (int c = 1; c <= 60 && dcyc < 0; c++) begin
            tick();
            if (sclkb && !ps) begin
                if (r1 < 0) r1 = c;
                else if (r2 < 0) r2 = c;
            end
            ps = sclkb;
            if (doneb != 2'b00) begin
                dcyc = c;
                dval = doneb;
                rxw  = rxb;
                reqb = 2'b00;
            end
        end
        reqb = 2'b00;
        chk("fast_rise1", r1, 3);
        chk("fast_rise2", r2, 5);
        chk("fast_dcyc", dcyc, 19);
        chk("fast_done", 32'(dval), 32'h1);
        chk("fast_rx", 32'(rxw), 32'h96);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
